// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller / checker.
// State encoding, word-offset constant and the word-address compare helper.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    // Byte-offset bits dropped when comparing addresses at word granularity.
    localparam int WORD_OFS   = 2;
    // Widest byte address the compare helper accepts; callers zero-extend.
    localparam int ADDR_MAX_W = 64;

    // True when two byte addresses fall in the same 32-bit word.
    function automatic logic word_eq(input logic [ADDR_MAX_W-1:0] a,
                                     input logic [ADDR_MAX_W-1:0] b);
        return ((a ^ b) >> WORD_OFS) == '0;
    endfunction

endpackage

// File: rtl/run_ctrl_watch_ch.sv
// One watch channel: latched enable/address/expected value, the snoop
// match compare, and the sticky seen flag plus last-write-wins hit flag.
module run_ctrl_watch_ch
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_exp,
    input  logic              snoop_en,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              en,
    output logic              hit,
    output logic              seen,
    output logic              mismatch_now
);

    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              hit_q, hit_d;
    logic              seen_q, seen_d;
    logic              match;

    // Config capture on the release edge; flag update on every matching write.
    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        exp_d  = exp_q;
        hit_d  = hit_q;
        seen_d = seen_q;
        match  = snoop_en && dmem_we && en_q &&
                 word_eq(ADDR_MAX_W'(dmem_addr), ADDR_MAX_W'(addr_q));
        mismatch_now = match && (dmem_wdata != exp_q);
        if (cfg_load) begin
            en_d   = cfg_en;
            addr_d = cfg_addr;
            exp_d  = cfg_exp;
        end
        if (match) begin
            seen_d = 1'b1;
            hit_d  = (dmem_wdata == exp_q);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            exp_q  <= '0;
            hit_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            exp_q  <= exp_d;
            hit_q  <= hit_d;
            seen_q <= seen_d;
        end
    end

    assign en   = en_q;
    assign hit  = hit_q;
    assign seen = seen_q;

endmodule

// File: rtl/run_ctrl_checker.sv
// Run controller / self-checker: holds the CPU in reset for RESET_CYCLES,
// counts run cycles, snoops data-memory writes on N_WATCH channels and
// settles in PASS or FAIL.
// Optional macro RUN_CTRL_STRICT_EN: any mismatching watched write fails
// the run immediately and the lowest offending channel is reported on
// first_bad_ch.
module run_ctrl_checker
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int N_WATCH      = 2,
    parameter int RESET_CYCLES = 3,
    parameter int MAX_CYCLES   = 250,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      cpu_reset,
    input  logic                      dmem_we,
    input  logic [ADDR_W-1:0]         dmem_addr,
    input  logic [DATA_W-1:0]         dmem_wdata,
    input  logic [N_WATCH-1:0]        watch_en,
    input  logic [N_WATCH*ADDR_W-1:0] watch_addr,
    input  logic [N_WATCH*DATA_W-1:0] watch_exp,
    output logic [N_WATCH-1:0]        hit_mask,
    output logic [N_WATCH-1:0]        seen_mask,
    output logic [CNT_W-1:0]          cycle_count,
    output logic                      done,
`ifdef RUN_CTRL_STRICT_EN
    output logic [((N_WATCH > 1) ? $clog2(N_WATCH) : 1)-1:0] first_bad_ch,
`endif
    output logic                      pass
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_load;
    logic               snoop_en;
    logic               all_ok;
    logic [N_WATCH-1:0] en_vec;
    logic [N_WATCH-1:0] mismatch_vec;

    assign snoop_en = (state_q == ST_RUN);
    assign all_ok   = &(~en_vec | hit_mask);

    for (genvar i = 0; i < N_WATCH; i++) begin : g_ch
        run_ctrl_watch_ch #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .cfg_load     (cfg_load),
            .cfg_en       (watch_en[i]),
            .cfg_addr     (watch_addr[i*ADDR_W +: ADDR_W]),
            .cfg_exp      (watch_exp[i*DATA_W +: DATA_W]),
            .snoop_en     (snoop_en),
            .dmem_we      (dmem_we),
            .dmem_addr    (dmem_addr),
            .dmem_wdata   (dmem_wdata),
            .en           (en_vec[i]),
            .hit          (hit_mask[i]),
            .seen         (seen_mask[i]),
            .mismatch_now (mismatch_vec[i])
        );
    end

`ifdef RUN_CTRL_STRICT_EN
    localparam int CH_W = (N_WATCH > 1) ? $clog2(N_WATCH) : 1;
    logic [CH_W-1:0] bad_q, bad_d;
    logic [CH_W-1:0] bad_idx;
    logic            any_bad;

    // Lowest-index channel whose current write mismatches.
    always_comb begin
        bad_idx = '0;
        for (int i = N_WATCH - 1; i >= 0; i--) begin
            if (mismatch_vec[i]) bad_idx = CH_W'(i);
        end
    end

    assign any_bad      = snoop_en && (|mismatch_vec);
    assign first_bad_ch = bad_q;
`else
    logic unused_mismatch;
    assign unused_mismatch = ^mismatch_vec;
`endif

    // Next-state, hold counter and run-cycle counter.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        cfg_load = 1'b0;
`ifdef RUN_CTRL_STRICT_EN
        bad_d    = bad_q;
`endif
        case (state_q)
            ST_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d  = ST_RUN;
                    cfg_load = 1'b1;
                end
            end
            ST_RUN: begin
`ifdef RUN_CTRL_STRICT_EN
                if (any_bad) begin
                    state_d = ST_FAIL;
                    bad_d   = bad_idx;
                end else
`endif
                if (all_ok) begin
                    state_d = ST_PASS;
                end else if (cnt_q == CNT_W'(MAX_CYCLES)) begin
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;  // PASS/FAIL are terminal until reset
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            cnt_q   <= '0;
`ifdef RUN_CTRL_STRICT_EN
            bad_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
`ifdef RUN_CTRL_STRICT_EN
            bad_q   <= bad_d;
`endif
        end
    end

    assign cpu_reset   = (state_q == ST_HOLD);
    assign cycle_count = cnt_q;
    assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass        = (state_q == ST_PASS);

endmodule

// File: doc/run_ctrl_checker.md
Name: run_ctrl_checker

Overview:
- Self-checking run controller for the pipelined CPU. It replaces fixed-delay reset release and fixed-time finish with cycle-exact control.
- It holds the CPU in reset for a programmable number of cycles, then counts run cycles.
- It snoops data-memory writes against N watched word addresses and expected values, and reports PASS or FAIL (timeout, or a strict mismatch).
- Sits beside CPU in the bench top and is fully synthesisable, so it can also serve FPGA bring-up.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- DATA_W, 32, data-memory write-data width.
- N_WATCH, 2, number of watch channels (>=1).
- RESET_CYCLES, 3, cycles cpu_reset stays high after reset deasserts (>=1).
- MAX_CYCLES, 250, run-cycle budget before timeout (>=1).
- CNT_W, 16, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- cpu_reset  out  1  active-high reset driven to CPU.
- dmem_we  in  1  snooped data-memory write enable.
- dmem_addr  in  ADDR_W  snooped byte address.
- dmem_wdata  in  DATA_W  snooped write data.
- watch_en  in  N_WATCH  per-channel enable.
- watch_addr  in  N_WATCH*ADDR_W  channel i byte address at [i*ADDR_W +: ADDR_W].
- watch_exp  in  N_WATCH*DATA_W  channel i expected value.
- hit_mask  out  N_WATCH  channel's most recent write equalled its expected value.
- seen_mask  out  N_WATCH  channel has been written at least once (sticky).
- cycle_count  out  CNT_W  run cycles elapsed.
- done  out  1  terminal state reached.
- pass  out  1  valid only when done=1.

Behaviour:
- Reset (reset=0, async) → state HOLD, cpu_reset=1, hold counter=0, cycle_count=0, hit_mask=0, seen_mask=0, done=0, pass=0.
- Channel state:
  - HOLD: hold counter increments each edge. On the edge where the counter reaches RESET_CYCLES-1, the next state is RUN, cpu_reset drops to 0, and watch_en, watch_addr and watch_exp are latched.
  - Config inputs are ignored outside that edge.
  - Snooped writes are ignored in HOLD.
- RUN:
  - Every edge, cycle_count increments.
  - A write matches channel i if dmem_we=1, latched en[i]=1 and dmem_addr[ADDR_W-1:2]==latched addr[i][ADDR_W-1:2]; byte offset is ignored.
  - On a match: seen[i]=1 and hit[i]=(dmem_wdata==exp[i]). The last write wins, so a later correct write clears a failure.
  - One write may match several channels; all of them update.
- Completion (evaluated on registered flags, one cycle after the causing write edge):
  - all_ok = for every i, en[i]=0 or hit[i]=1.
  - If all_ok → PASS (done=1, pass=1).
  - Else, if cycle_count==MAX_CYCLES → FAIL (done=1, pass=0).
  - all_ok and timeout in the same cycle → PASS wins.
  - All channels disabled → PASS on the first RUN evaluation.
- PASS/FAIL: terminal until reset.
  - cycle_count, hit_mask and seen_mask freeze.
  - cpu_reset stays 0; the CPU keeps running, and the bench decides when to $finish.
- Counter never wraps; it freezes at MAX_CYCLES in FAIL.
- Reset mid-RUN: async return to HOLD, all flags cleared, config re-latched on the next HOLD→RUN.

Optional Feature:
- Macro RUN_CTRL_STRICT_EN.
- Defined: in RUN, any matching write with dmem_wdata!=exp[i] sends the state to FAIL at the next edge (done=1, pass=0). This takes priority over an all_ok evaluated in the same cycle. Adds output first_bad_ch (width $clog2(N_WATCH), min 1), the lowest mismatching channel index, captured once.
- Undefined: mismatches only clear hit[i] (last write wins). The first_bad_ch port does not exist.

Decomposition:
- Package run_ctrl_pkg holds:
  - state encoding (HOLD=2'd0, RUN=2'd1, PASS=2'd2, FAIL=2'd3);
  - word-offset constant (2);
  - helper function for word-address compare.
- Sub-module run_ctrl_watch_ch, instantiated N_WATCH times in a generate loop. Each instance contains the latched addr/exp/en, the match compare, and the seen/hit flops. It exports hit, seen and mismatch_now.
- Top holds the FSM, hold counter and cycle counter.

Test Plan:
- Hold release: reset low 2 cycles then high, RESET_CYCLES=3 → cpu_reset high for exactly 3 edges after release, then 0; cycle_count=0 on the first RUN cycle.
- GCD program:
  - Stimulus: RAM[1]=66, RAM[2]=121, ch0 addr 0x0C exp 11, ch1 disabled.
  - Required: pass=1 one cycle after the write of 11 to 0x0C; cycle_count < MAX_CYCLES.
- Last-write-wins (strict off):
  - Stimulus: writes 0x99 then 11 to 0x0C.
  - Required: hit[0] goes 0 then 1, seen[0]=1, PASS.
  - With RUN_CTRL_STRICT_EN: FAIL after the 0x99 write, first_bad_ch=0.
- Timeout: MAX_CYCLES=20, no watched writes → FAIL at cycle_count=20, seen_mask=0, frozen thereafter.
- Simultaneous:
  - Stimulus: correct write lands so that all_ok and cycle_count==MAX_CYCLES coincide; separately, one write whose address matches ch0 and ch1 (both addr 0x10, exp 5).
  - Required: PASS in both cases.
- Async reset mid-RUN: assert reset at cycle 7 → immediate HOLD, cpu_reset=1, masks 0, done=0; re-run completes normally.
